exe_pg_sequencer: RTL and testbench
===================================

Name: exe_pg_sequencer

Overview:
- Power-gating sequencer for the Exe0 multiplier and shifter power domains.
- Consumes the per-instruction mul/sh flags produced by the Dec0 instruction PG decoder, together with the instruction valid.
- Drives each domain's sleep and isolation controls.
- Stalls the decode stage while a requested domain is waking, so no mul/sh instruction ever issues to a gated unit.

Parameters:
- WAKE_LAT, 4, cycles the domain stays in WAKE before isolation release; legal range 1..255.
- IDLE_TH, 16, consecutive idle ACTIVE cycles before the domain gates; legal range 1..255.
- CNT_W, 8, width of the internal wake/idle counters.

Ports:
- clk_i_pgs  in  1  clock.
- rst_i_pgs  in  1  synchronous active-high reset.
- valid_i_pgs  in  1  Dec0 instruction valid.
- mul_ins_i_pgs  in  1  instruction uses the multiplier (from the PG decoder).
- sh_ins_i_pgs  in  1  instruction uses the shifter (from the PG decoder).
- stall_o_pgs  out  1  hold Dec0; the instruction is not issued this cycle.
- mul_sleep_o_pgs  out  1  multiplier power switch off.
- mul_iso_o_pgs  out  1  multiplier output isolation.
- sh_sleep_o_pgs  out  1  shifter power switch off.
- sh_iso_o_pgs  out  1  shifter output isolation.

Behaviour:
- Clock and reset: one clock, clk_i_pgs. Reset rst_i_pgs is synchronous and active-high.
- Domain controllers: two independent, identical controllers (mul, sh).
- Per-domain request: req = valid_i_pgs & flag.
- States: SLEEP, WAKE, ACTIVE, ISO. Registered outputs per state (sleep, iso):
  - SLEEP = (1,1)
  - WAKE = (0,1)
  - ACTIVE = (0,0)
  - ISO = (0,1)
- Reset: both domains go to SLEEP, so sleep=1 and iso=1. Reset mid-sequence from any state forces SLEEP on the next edge and clears all counters.
- SLEEP: on req, go to WAKE and clear the wake counter.
- WAKE: the wake counter increments each cycle. At count == WAKE_LAT-1, go to ACTIVE. WAKE therefore lasts exactly WAKE_LAT cycles. The wake completes even if req drops.
- ACTIVE:
  - A cycle with req clears the idle counter.
  - Otherwise the idle counter increments.
  - When the counter reaches IDLE_TH-1 in a cycle without req, go to ISO. Result: ISO is entered after IDLE_TH consecutive idle cycles.
- ISO: lasts one cycle (isolate before power-off).
  - With req: return to ACTIVE (abort gating).
  - Otherwise: go to SLEEP.
- stall_o_pgs:
  - Combinational: asserted when any domain has req and that domain is not ACTIVE.
  - Deasserted during reset.
  - Upstream holds valid and flags stable while stalled.
- Stall latency:
  - From SLEEP: the instruction is stalled WAKE_LAT+1 cycles and issues in the first ACTIVE cycle.
  - From ISO: stalled 1 cycle.
- Both flags set on one instruction: both domains sequence in parallel. Stall persists until both are ACTIVE.
- A domain not requested by the current instruction continues its own idle countdown unaffected.
- Counters never wrap: the wake counter is bounded by WAKE_LAT and the idle counter by IDLE_TH.

Optional Feature:
- Macro: PG_STATS_EN.
- When defined:
  - Adds outputs mul_wake_cnt_o_pgs and sh_wake_cnt_o_pgs, each 16-bit.
  - Each counter increments on the corresponding SLEEP->WAKE transition and saturates at 16'hFFFF.
  - Reset to 0.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pg_pkg holds:
  - state encodings PG_SLEEP=2'd0, PG_WAKE=2'd1, PG_ACTIVE=2'd2, PG_ISO=2'd3;
  - the default WAKE_LAT and IDLE_TH constants.
- Sub-module pg_domain_fsm (state, wake/idle counters, sleep/iso/ready outputs) is instantiated twice.
- Top level combines the two ready signals into stall and hosts the optional stats.

Test Plan:
- Release reset with no instructions -> both domains sleep=1, iso=1, stall=0 indefinitely.
- valid=1, mul=1 from SLEEP (WAKE_LAT=4) -> stall high 5 cycles; mul_sleep falls at cycle 1, mul_iso falls at cycle 5; instruction issues at cycle 5; sh stays asleep.
- After the mul issue, 16 idle cycles -> mul_iso=1 on cycle 17; mul_sleep=1 on cycle 18.
- mul request arriving in the ISO cycle -> stall for 1 cycle, return to ACTIVE, mul_sleep never rises.
- valid with mul=1 and sh=1, both asleep -> both wake in parallel; stall for 5 cycles; single issue.
- Reset asserted on the 2nd WAKE cycle -> SLEEP next edge, stall=0.
- With PG_STATS_EN: three sleep/wake cycles -> mul_wake_cnt=3.

Source files
------------

// File: rtl/pg_pkg.sv
// -----------------------------------------------------------------------------
// pg_pkg
// Shared definitions for the Exe0 power-gating sequencer:
//   - pg_state_e : per-domain controller state encoding
//   - default wake latency, idle threshold and counter width
// -----------------------------------------------------------------------------
package pg_pkg;

    typedef enum logic [1:0] {
        PG_SLEEP  = 2'd0,
        PG_WAKE   = 2'd1,
        PG_ACTIVE = 2'd2,
        PG_ISO    = 2'd3
    } pg_state_e;

    localparam int unsigned PG_WAKE_LAT_DEF = 4;
    localparam int unsigned PG_IDLE_TH_DEF  = 16;
    localparam int unsigned PG_CNT_W_DEF    = 8;

endpackage : pg_pkg

// File: rtl/pg_domain_fsm.sv
// -----------------------------------------------------------------------------
// pg_domain_fsm
// Power-gating controller for a single Exe0 power domain.
//   SLEEP  : switch off, isolated          (sleep=1, iso=1)
//   WAKE   : switch on, still isolated     (sleep=0, iso=1), WAKE_LAT cycles
//   ACTIVE : powered and usable            (sleep=0, iso=0)
//   ISO    : one-cycle isolate before power-off (sleep=0, iso=1)
//
// Ports:
//   clk_i    in   clock
//   rst_i    in   synchronous active-high reset
//   req_i    in   an instruction for this domain is present in Dec0
//   sleep_o  out  power switch off (registered)
//   iso_o    out  output isolation (registered)
//   ready_o  out  domain is ACTIVE and may accept an instruction (registered)
// -----------------------------------------------------------------------------
module pg_domain_fsm
    import pg_pkg::*;
#(
    parameter int unsigned WAKE_LAT = PG_WAKE_LAT_DEF,
    parameter int unsigned IDLE_TH  = PG_IDLE_TH_DEF,
    parameter int unsigned CNT_W    = PG_CNT_W_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    output logic sleep_o,
    output logic iso_o,
    output logic ready_o
);

    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_LAT - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TH - 1);

    pg_state_e        state_q;
    logic [CNT_W-1:0] wake_cnt_q;
    logic [CNT_W-1:0] idle_cnt_q;
    logic             sleep_q;
    logic             iso_q;
    logic             ready_q;

    // Outputs are registered alongside the state so they change on the same
    // edge as the state they describe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= PG_SLEEP;
            wake_cnt_q <= '0;
            idle_cnt_q <= '0;
            sleep_q    <= 1'b1;
            iso_q      <= 1'b1;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                PG_SLEEP: begin
                    if (req_i) begin
                        state_q    <= PG_WAKE;
                        wake_cnt_q <= '0;
                        sleep_q    <= 1'b0;
                        iso_q      <= 1'b1;
                        ready_q    <= 1'b0;
                    end
                end
                PG_WAKE: begin
                    // The wake always runs to completion, even if the
                    // request has gone away in the meantime.
                    if (wake_cnt_q == WAKE_LAST) begin
                        state_q    <= PG_ACTIVE;
                        idle_cnt_q <= '0;
                        sleep_q    <= 1'b0;
                        iso_q      <= 1'b0;
                        ready_q    <= 1'b1;
                    end else begin
                        wake_cnt_q <= wake_cnt_q + 1'b1;
                    end
                end
                PG_ACTIVE: begin
                    if (req_i) begin
                        idle_cnt_q <= '0;
                    end else if (idle_cnt_q == IDLE_LAST) begin
                        state_q    <= PG_ISO;
                        idle_cnt_q <= '0;
                        sleep_q    <= 1'b0;
                        iso_q      <= 1'b1;
                        ready_q    <= 1'b0;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + 1'b1;
                    end
                end
                PG_ISO: begin
                    if (req_i) begin
                        // Late request: abort gating, the rail never dropped.
                        state_q    <= PG_ACTIVE;
                        idle_cnt_q <= '0;
                        sleep_q    <= 1'b0;
                        iso_q      <= 1'b0;
                        ready_q    <= 1'b1;
                    end else begin
                        state_q    <= PG_SLEEP;
                        sleep_q    <= 1'b1;
                        iso_q      <= 1'b1;
                        ready_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= PG_SLEEP;
                    wake_cnt_q <= '0;
                    idle_cnt_q <= '0;
                    sleep_q    <= 1'b1;
                    iso_q      <= 1'b1;
                    ready_q    <= 1'b0;
                end
            endcase
        end
    end

    assign sleep_o = sleep_q;
    assign iso_o   = iso_q;
    assign ready_o = ready_q;

endmodule : pg_domain_fsm

// File: rtl/exe_pg_sequencer.sv
// -----------------------------------------------------------------------------
// exe_pg_sequencer
// Power-gating sequencer for the Exe0 multiplier (index 0) and shifter
// (index 1) domains. Each domain is handled by its own pg_domain_fsm; this
// level forms the per-domain requests and stalls Dec0 while any requested
// domain is not yet ACTIVE.
//
// Optional build macro: PG_STATS_EN adds 16-bit saturating SLEEP->WAKE
// counters per domain (mul_wake_cnt_o_pgs, sh_wake_cnt_o_pgs).
//
// Ports:
//   clk_i_pgs        in   clock
//   rst_i_pgs        in   synchronous active-high reset
//   valid_i_pgs      in   Dec0 instruction valid
//   mul_ins_i_pgs    in   instruction uses the multiplier
//   sh_ins_i_pgs     in   instruction uses the shifter
//   stall_o_pgs      out  hold Dec0 (combinational)
//   mul_sleep_o_pgs  out  multiplier power switch off
//   mul_iso_o_pgs    out  multiplier output isolation
//   sh_sleep_o_pgs   out  shifter power switch off
//   sh_iso_o_pgs     out  shifter output isolation
//   mul_wake_cnt_o_pgs / sh_wake_cnt_o_pgs  out [15:0]  (PG_STATS_EN only)
// -----------------------------------------------------------------------------
module exe_pg_sequencer
    import pg_pkg::*;
#(
    parameter int unsigned WAKE_LAT = PG_WAKE_LAT_DEF,
    parameter int unsigned IDLE_TH  = PG_IDLE_TH_DEF,
    parameter int unsigned CNT_W    = PG_CNT_W_DEF
) (
    input  logic        clk_i_pgs,
    input  logic        rst_i_pgs,
    input  logic        valid_i_pgs,
    input  logic        mul_ins_i_pgs,
    input  logic        sh_ins_i_pgs,
    output logic        stall_o_pgs,
    output logic        mul_sleep_o_pgs,
    output logic        mul_iso_o_pgs,
    output logic        sh_sleep_o_pgs,
    output logic        sh_iso_o_pgs
`ifdef PG_STATS_EN
    ,
    output logic [15:0] mul_wake_cnt_o_pgs,
    output logic [15:0] sh_wake_cnt_o_pgs
`endif
);

    logic [1:0] req_w;
    logic [1:0] sleep_w;
    logic [1:0] iso_w;
    logic [1:0] ready_w;

    assign req_w = {valid_i_pgs & sh_ins_i_pgs, valid_i_pgs & mul_ins_i_pgs};

    for (genvar gi = 0; gi < 2; gi++) begin : g_dom
        pg_domain_fsm #(
            .WAKE_LAT (WAKE_LAT),
            .IDLE_TH  (IDLE_TH),
            .CNT_W    (CNT_W)
        ) u_fsm (
            .clk_i   (clk_i_pgs),
            .rst_i   (rst_i_pgs),
            .req_i   (req_w[gi]),
            .sleep_o (sleep_w[gi]),
            .iso_o   (iso_w[gi]),
            .ready_o (ready_w[gi])
        );
    end

    // Any requested domain that is not ready holds the instruction.
    assign stall_o_pgs     = ~rst_i_pgs & (|(req_w & ~ready_w));

    assign mul_sleep_o_pgs = sleep_w[0];
    assign mul_iso_o_pgs   = iso_w[0];
    assign sh_sleep_o_pgs  = sleep_w[1];
    assign sh_iso_o_pgs    = iso_w[1];

`ifdef PG_STATS_EN
    logic [15:0] wake_cnt_q [2];

    // sleep_w is high exactly when the domain sits in SLEEP, so a request
    // seen there is a SLEEP->WAKE transition on the coming edge.
    for (genvar gi = 0; gi < 2; gi++) begin : g_stats
        always_ff @(posedge clk_i_pgs) begin
            if (rst_i_pgs) begin
                wake_cnt_q[gi] <= '0;
            end else if (req_w[gi] && sleep_w[gi] && (wake_cnt_q[gi] != 16'hFFFF)) begin
                wake_cnt_q[gi] <= wake_cnt_q[gi] + 16'd1;
            end
        end
    end

    assign mul_wake_cnt_o_pgs = wake_cnt_q[0];
    assign sh_wake_cnt_o_pgs  = wake_cnt_q[1];
`endif

endmodule : exe_pg_sequencer

// File: tb/tb_exe_pg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_exe_pg_sequencer
// Drives directed then randomised instruction streams into exe_pg_sequencer.
// A timestamp-based reference model predicts every cycle's outputs; the
// expectation is queued by the driver and compared by an independent monitor
// on the falling edge. Define PG_STATS_EN to also check the wake counters.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_exe_pg_sequencer;

    localparam int WAKE_LAT = 4;
    localparam int IDLE_TH  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        mul = 1'b0;
    logic        sh = 1'b0;
    logic        stall;
    logic        mul_sleep, mul_iso, sh_sleep, sh_iso;
    logic [15:0] mul_wc, sh_wc;

    always #5 clk = ~clk;

    exe_pg_sequencer #(
        .WAKE_LAT (WAKE_LAT),
        .IDLE_TH  (IDLE_TH),
        .CNT_W    (8)
    ) dut (
        .clk_i_pgs       (clk),
        .rst_i_pgs       (rst),
        .valid_i_pgs     (valid),
        .mul_ins_i_pgs   (mul),
        .sh_ins_i_pgs    (sh),
        .stall_o_pgs     (stall),
        .mul_sleep_o_pgs (mul_sleep),
        .mul_iso_o_pgs   (mul_iso),
        .sh_sleep_o_pgs  (sh_sleep),
        .sh_iso_o_pgs    (sh_iso)
`ifdef PG_STATS_EN
        ,
        .mul_wake_cnt_o_pgs (mul_wc),
        .sh_wake_cnt_o_pgs  (sh_wc)
`endif
    );

`ifndef PG_STATS_EN
    assign mul_wc = 16'd0;
    assign sh_wc  = 16'd0;
`endif

    typedef struct packed {
        logic [4:0]  ctl;   // {stall, mul_sleep, mul_iso, sh_sleep, sh_iso}
        logic [15:0] wc0;
        logic [15:0] wc1;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: a domain is either asleep, or awake with a known
    // activation time and a "last busy" cycle. Idle gating happens
    // IDLE_TH+1 cycles after the last busy cycle.
    bit sleeping [2];
    int active_at [2];
    int last_busy [2];
    int wakes [2];
    int t = 0;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            sleeping[d]  = 1'b1;
            active_at[d] = 0;
            last_busy[d] = 0;
            wakes[d]     = 0;
        end
    endtask

    // Drive one cycle (we are just after a rising edge), predict, advance.
    task automatic step(input bit r, input bit v, input bit m, input bit s, output bit st);
        exp_t e;
        bit   req [2];
        bit   rdy [2];
        bit   slp [2];
        bit   iso [2];
        bit   in_iso [2];
        rst = r; valid = v; mul = m; sh = s;
        req[0] = v & m;
        req[1] = v & s;
        for (int d = 0; d < 2; d++) begin
            in_iso[d] = 1'b0;
            if (sleeping[d]) begin
                slp[d] = 1'b1; iso[d] = 1'b1; rdy[d] = 1'b0;
            end else if (t < active_at[d]) begin
                slp[d] = 1'b0; iso[d] = 1'b1; rdy[d] = 1'b0;
            end else if (t == last_busy[d] + IDLE_TH + 1) begin
                slp[d] = 1'b0; iso[d] = 1'b1; rdy[d] = 1'b0; in_iso[d] = 1'b1;
            end else begin
                slp[d] = 1'b0; iso[d] = 1'b0; rdy[d] = 1'b1;
            end
        end
        st = !r && ((req[0] && !rdy[0]) || (req[1] && !rdy[1]));
        e.ctl = {st, slp[0], iso[0], slp[1], iso[1]};
        e.wc0 = 16'(wakes[0]);
        e.wc1 = 16'(wakes[1]);
        e.cyc = t;
        sb.push_back(e);
        if (v && !st && !r)
            $display("ISSUE t=%0d mul=%0b sh=%0b", t, m, s);
        if (r) begin
            model_reset();
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (sleeping[d]) begin
                    if (req[d]) begin
                        sleeping[d]  = 1'b0;
                        active_at[d] = t + 1 + WAKE_LAT;
                        last_busy[d] = active_at[d] - 1;
                        if (wakes[d] < 16'hFFFF) wakes[d]++;
                    end
                end else if (t < active_at[d]) begin
                    // waking: nothing changes
                end else if (in_iso[d]) begin
                    if (req[d]) last_busy[d] = t;
                    else        sleeping[d] = 1'b1;
                end else if (req[d]) begin
                    last_busy[d] = t;
                end
            end
        end
        t++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit st;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, st);
    endtask

    // Hold an instruction until the model says it issues (bounded).
    task automatic issue(input bit m, input bit s);
        bit st;
        int n = 0;
        do begin
            step(1'b0, 1'b1, m, s, st);
            n++;
        end while (st && n < 50);
    endtask

    // Monitor: compare whatever the DUT presents against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({stall, mul_sleep, mul_iso, sh_sleep, sh_iso} !== e.ctl) begin
                    errors++;
                    $display("FAIL ctl t=%0d {stall,msl,miso,ssl,siso} got=%b exp=%b",
                             e.cyc, {stall, mul_sleep, mul_iso, sh_sleep, sh_iso}, e.ctl);
                end
`ifdef PG_STATS_EN
                checks++;
                if (mul_wc !== e.wc0 || sh_wc !== e.wc1) begin
                    errors++;
                    $display("FAIL wake_cnt t=%0d got=%0d/%0d exp=%0d/%0d",
                             e.cyc, mul_wc, sh_wc, e.wc0, e.wc1);
                end
`endif
            end
        end
    end

    initial begin
        bit st;
        bit cv, cm, cs, cr;
        int dens;
        int w;
        model_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;

        // Idle after reset: everything asleep, no stall.
        idle(30);
        // Multiplier wake from SLEEP, then 16 idle cycles into ISO.
        issue(1'b1, 1'b0);
        idle(IDLE_TH);
        // Request lands in the ISO cycle: one-cycle stall, no power-off.
        issue(1'b1, 1'b0);
        idle(IDLE_TH + 6);
        // Both domains from SLEEP in parallel.
        issue(1'b1, 1'b1);
        idle(IDLE_TH + 6);
        // Reset on the 2nd WAKE cycle of the shifter.
        step(1'b0, 1'b1, 1'b0, 1'b1, st);
        step(1'b0, 1'b1, 1'b0, 1'b1, st);
        step(1'b1, 1'b1, 1'b0, 1'b1, st);
        idle(5);
        // Third multiplier wake for the stats counter.
        issue(1'b1, 1'b0);
        idle(IDLE_TH + 4);
        issue(1'b1, 1'b0);
        idle(3);

        // Randomised traffic with density segments; inputs held while stalled.
        cv = 1'b0; cm = 1'b0; cs = 1'b0; st = 1'b0; dens = 30;
        for (int i = 0; i < 1500; i++) begin
            if (i % 60 == 0) begin
                w = int'($urandom_range(0, 3));
                dens = (w == 0) ? 0 : (w == 1) ? 5 : (w == 2) ? 30 : 70;
            end
            if (!st) begin
                cv = ($urandom_range(0, 99) < dens);
                cm = 1'($urandom_range(0, 1));
                cs = 1'($urandom_range(0, 1));
            end
            cr = ($urandom_range(0, 299) == 0);
            step(cr, cv, cm, cs, st);
        end
        idle(2);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_exe_pg_sequencer
